// File: rtl/mem_dma_init_if.sv
// Memory read/write port bundle for the init/copy DMA engine.
// Read response returns one cycle after rready; writes are fire-and-forget.
interface mem_dma_init_if;
  logic        rready;
  logic [29:0] raddr;
  logic        rresp;
  logic [31:0] rdata;
  logic        wready;
  logic [29:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  modport master (
    output rready, raddr, wready, waddr, wdata, wstrb,
    input  rresp, rdata
  );

  modport slave (
    input  rready, raddr, wready, waddr, wdata, wstrb,
    output rresp, rdata
  );
endinterface

// File: rtl/mem_dma_init.sv
// Word DMA engine: memory-to-memory copy or constant fill, one word per cycle.
// All outputs registered; copy done at len+3 cycles after start, fill at len+1.
module mem_dma_init #(
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            start,
  input  logic [29:0]     src_addr,
  input  logic [29:0]     dst_addr,
  input  logic [LENW-1:0] len,
  input  logic            fill_en,
  input  logic [31:0]     fill_data,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  mem_dma_init_if.master  mem
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t          state, state_n;
  logic            fill_q, fill_n;
  logic [31:0]     fdat_q, fdat_n;
  logic [LENW-1:0] rcnt_q, rcnt_n;
  logic [LENW-1:0] wcnt_q, wcnt_n;
  logic [29:0]     wptr_q, wptr_n;
  logic            rpend_q, rpend_n;
  logic            rready_q, rready_n;
  logic [29:0]     raddr_q, raddr_n;
  logic            wready_q, wready_n;
  logic [29:0]     waddr_q, waddr_n;
  logic [31:0]     wdata_q, wdata_n;
  logic [3:0]      wstrb_q;
  logic            busy_q, done_q, err_q, done_n, err_n;
  logic            issue_w, overlap;

  // A copy whose destination starts inside the source window would read back
  // its own writes, so it is rejected up front.
  assign overlap = (dst_addr > src_addr) && (dst_addr < (src_addr + 30'(len)));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fill_n   = fill_q;
    fdat_n   = fdat_q;
    rcnt_n   = rcnt_q;
    wcnt_n   = wcnt_q;
    wptr_n   = wptr_q;
    rpend_n  = rpend_q;
    rready_n = rready_q;
    raddr_n  = raddr_q;
    wready_n = wready_q;
    waddr_n  = waddr_q;
    wdata_n  = wdata_q;
    err_n    = 1'b0;
    issue_w  = 1'b0;
    case (state)
      IDLE: begin
        rready_n = 1'b0;
        wready_n = 1'b0;
        rpend_n  = 1'b0;
        if (start) begin
          if (len == '0) begin
            state_n = FINISH;
          end else if (!fill_en && overlap) begin
            err_n = 1'b1;
          end else begin
            state_n = RUN;
            fill_n  = fill_en;
            fdat_n  = fill_data;
            if (fill_en) begin
              wready_n = 1'b1;
              waddr_n  = dst_addr;
              wdata_n  = fill_data;
              wptr_n   = dst_addr + 30'd1;
              wcnt_n   = len - LENW'(1);
              if (len == LENW'(1)) state_n = DRAIN;
            end else begin
              rready_n = 1'b1;
              raddr_n  = src_addr;
              rcnt_n   = len - LENW'(1);
              wptr_n   = dst_addr;
              wcnt_n   = len;
            end
          end
        end
      end
      RUN, DRAIN: begin
        rpend_n = rready_q;
        issue_w = fill_q ? (wcnt_q != '0) : (rpend_q && mem.rresp && (wcnt_q != '0));
        wready_n = issue_w;
        if (issue_w) begin
          waddr_n = wptr_q;
          wptr_n  = wptr_q + 30'd1;
          wcnt_n  = wcnt_q - LENW'(1);
          wdata_n = fill_q ? fdat_q : mem.rdata;
        end
        if (state == RUN) begin
          if (fill_q) begin
            if (issue_w && (wcnt_q == LENW'(1))) state_n = DRAIN;
          end else if (rready_q) begin
            if (rcnt_q == '0) begin
              rready_n = 1'b0;
              state_n  = DRAIN;
            end else begin
              raddr_n = raddr_q + 30'd1;
              rcnt_n  = rcnt_q - LENW'(1);
            end
          end
        end else if (wready_q && (wcnt_q == '0)) begin
          state_n = FINISH;
        end
        // Abort drops everything, including a read response still in flight.
        if (abort) begin
          state_n  = IDLE;
          rready_n = 1'b0;
          wready_n = 1'b0;
          rpend_n  = 1'b0;
        end
      end
      FINISH: begin
        state_n  = IDLE;
        rready_n = 1'b0;
        wready_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    done_n = (state_n == FINISH);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fill_q   <= 1'b0;
      fdat_q   <= '0;
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      wptr_q   <= '0;
      rpend_q  <= 1'b0;
      rready_q <= 1'b0;
      raddr_q  <= '0;
      wready_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fill_q   <= fill_n;
      fdat_q   <= fdat_n;
      rcnt_q   <= rcnt_n;
      wcnt_q   <= wcnt_n;
      wptr_q   <= wptr_n;
      rpend_q  <= rpend_n;
      rready_q <= rready_n;
      raddr_q  <= raddr_n;
      wready_q <= wready_n;
      waddr_q  <= waddr_n;
      wdata_q  <= wdata_n;
      wstrb_q  <= {4{wready_n}};
      busy_q   <= (state_n != IDLE);
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem.rready = rready_q;
  assign mem.raddr  = raddr_q;
  assign mem.wready = wready_q;
  assign mem.waddr  = waddr_q;
  assign mem.wdata  = wdata_q;
  assign mem.wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_dma_init.sv
// Directed bench for mem_dma_init with a one-cycle-latency memory model.
module tb_mem_dma_init;
  logic        clk = 1'b0;
  logic        resetb;
  logic        start, fill_en, abort;
  logic [29:0] src_addr, dst_addr;
  logic [15:0] len;
  logic [31:0] fill_data;
  logic        busy, done, err;
  int          passes = 0;
  int          total  = 0;
  logic [31:0] mem [logic [29:0]];

  mem_dma_init_if mif ();

  mem_dma_init #(.LENW(16)) dut (
    .clk(clk), .resetb(resetb), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_en(fill_en), .fill_data(fill_data),
    .abort(abort), .busy(busy), .done(done), .err(err), .mem(mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mif.rresp <= 1'b0;
      mif.rdata <= '0;
    end else begin
      mif.rresp <= mif.rready;
      mif.rdata <= mem.exists(mif.raddr) ? mem[mif.raddr] : 32'h0;
      if (mif.wready) mem[mif.waddr] = mif.wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic kick(input logic [29:0] s, input logic [29:0] d, input logic [15:0] l,
                      input logic f, input logic [31:0] fd);
    start = 1'b1; src_addr = s; dst_addr = d; len = l; fill_en = f; fill_data = fd;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  logic [31:0] cw [4];
  logic [29:0] rw [4];

  initial begin
    cw[0] = 32'hAAAA0001; cw[1] = 32'hBBBB0002; cw[2] = 32'hCCCC0003; cw[3] = 32'hDDDD0004;
    rw[0] = 30'h3ffffffe; rw[1] = 30'h3fffffff; rw[2] = 30'h0; rw[3] = 30'h1;
    resetb = 1'b0; start = 1'b0; abort = 1'b0; fill_en = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    repeat (2) @(negedge clk);
    chk("rst.outs", {busy, done, err, mif.rready, mif.wready, mif.wstrb}, 64'h0);
    chk("rst.addr", {mif.raddr, mif.waddr}, 64'h0);
    chk("rst.wdata", mif.wdata, 64'h0);
    resetb = 1'b1;
    @(negedge clk);

    // Copy 0x100 -> 0x200, four words
    for (int i = 0; i < 4; i++) mem[30'h100 + 30'(i)] = cw[i];
    kick(30'h100, 30'h200, 16'd4, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("copy.rready c%0d", c), mif.rready, (c <= 4));
      if (c <= 4) chk($sformatf("copy.raddr c%0d", c), mif.raddr, 30'h100 + 30'(c - 1));
      chk($sformatf("copy.wready c%0d", c), mif.wready, (c >= 3 && c <= 6));
      chk($sformatf("copy.wstrb c%0d", c), mif.wstrb, (c >= 3 && c <= 6) ? 4'hf : 4'h0);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("copy.waddr c%0d", c), mif.waddr, 30'h200 + 30'(c - 3));
        chk($sformatf("copy.wdata c%0d", c), mif.wdata, cw[c-3]);
      end
      chk($sformatf("copy.done c%0d", c), done, (c == 7));
      chk($sformatf("copy.busy c%0d", c), busy, (c <= 7));
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("copy.mem %0d", i), mem.exists(30'h200 + 30'(i)) ? mem[30'h200 + 30'(i)] : 32'hx, cw[i]);

    // Fill 0x40, three words
    kick(30'h0, 30'h40, 16'd3, 1'b1, 32'hDEADBEEF);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("fill.rready c%0d", c), mif.rready, 1'b0);
      chk($sformatf("fill.wready c%0d", c), mif.wready, (c <= 3));
      chk($sformatf("fill.wstrb c%0d", c), mif.wstrb, (c <= 3) ? 4'hf : 4'h0);
      if (c <= 3) begin
        chk($sformatf("fill.waddr c%0d", c), mif.waddr, 30'h40 + 30'(c - 1));
        chk($sformatf("fill.wdata c%0d", c), mif.wdata, 32'hDEADBEEF);
      end
      chk($sformatf("fill.done c%0d", c), done, (c == 4));
      @(negedge clk);
    end

    // Zero length
    kick(30'h5, 30'h6, 16'd0, 1'b0, 32'h0);
    chk("len0.done c1", {done, err, mif.rready, mif.wready}, 4'b1000);
    @(negedge clk);
    chk("len0.c2", {busy, done, mif.rready, mif.wready}, 4'b0000);
    @(negedge clk);

    // Overlapping copy rejected
    kick(30'h10, 30'h12, 16'd4, 1'b0, 32'h0);
    chk("ovl.c1", {busy, done, err, mif.rready, mif.wready}, 5'b00100);
    @(negedge clk);
    chk("ovl.c2", {busy, done, err, mif.rready, mif.wready}, 5'b00000);
    @(negedge clk);

    // Address wrap; a start while busy must be ignored
    kick(30'h3ffffffe, 30'h500, 16'd4, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 2) begin start = 1'b1; src_addr = 30'h0; len = 16'd1; fill_en = 1'b1; end
      if (c == 3) start = 1'b0;
      chk($sformatf("wrap.rready c%0d", c), mif.rready, (c <= 4));
      if (c <= 4) chk($sformatf("wrap.raddr c%0d", c), mif.raddr, rw[c-1]);
      if (c == 3) chk("wrap.waddr c3", mif.waddr, 30'h500);
      chk($sformatf("wrap.done c%0d", c), done, (c == 7));
      @(negedge clk);
    end

    // Abort in cycle 3 of an eight-word copy
    for (int i = 0; i < 8; i++) mem[30'h300 + 30'(i)] = 32'h30000000 + i;
    kick(30'h300, 30'h600, 16'd8, 1'b0, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("abt.rready c%0d", c), mif.rready, (c <= 3));
      if (c <= 3) chk($sformatf("abt.raddr c%0d", c), mif.raddr, 30'h300 + 30'(c - 1));
      chk($sformatf("abt.wready c%0d", c), mif.wready, (c == 3));
      chk($sformatf("abt.busy c%0d", c), busy, (c <= 3));
      chk($sformatf("abt.done c%0d", c), {done, err}, 2'b00);
      abort = (c == 3);
      @(negedge clk);
    end
    chk("abt.mem0", mem.exists(30'h600) ? mem[30'h600] : 32'hx, 32'h30000000);
    chk("abt.mem1 absent", mem.exists(30'h601), 1'b0);

    // Abort together with start in IDLE: start wins
    abort = 1'b1;
    kick(30'h0, 30'h900, 16'd1, 1'b1, 32'h00000005);
    chk("abst.c1", {mif.wready, mif.waddr, mif.wdata}, {1'b1, 30'h900, 32'h5});
    @(negedge clk);
    chk("abst.done c2", {done, mif.wready}, 2'b10);
    @(negedge clk);

    // Reset in the middle of a fill, then a fresh fill
    kick(30'h0, 30'h700, 16'd8, 1'b1, 32'h12345678);
    chk("rmid.c1", {mif.wready, mif.waddr}, {1'b1, 30'h700});
    @(negedge clk);
    chk("rmid.c2", {mif.wready, mif.waddr}, {1'b1, 30'h701});
    #1 resetb = 1'b0;
    #1;
    chk("rmid.outs", {busy, done, err, mif.rready, mif.wready, mif.wstrb}, 64'h0);
    chk("rmid.bus", {mif.raddr, mif.waddr}, 64'h0);
    chk("rmid.wdata", mif.wdata, 64'h0);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    chk("rmid.idle", {busy, mif.wready}, 2'b00);
    kick(30'h0, 30'h800, 16'd2, 1'b1, 32'hCAFEF00D);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("rnew.wready c%0d", c), mif.wready, (c <= 2));
      if (c <= 2) chk($sformatf("rnew.waddr c%0d", c), mif.waddr, 30'h800 + 30'(c - 1));
      chk($sformatf("rnew.done c%0d", c), done, (c == 3));
      @(negedge clk);
    end
    chk("rmid.mem700", mem.exists(30'h700) ? mem[30'h700] : 32'hx, 32'h12345678);
    chk("rmid.mem701 absent", mem.exists(30'h701), 1'b0);
    chk("rnew.mem801", mem.exists(30'h801) ? mem[30'h801] : 32'hx, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end by 200000");
    $fatal(1);
  end
endmodule
